// File: rtl/bus_select_rr_pkg.sv
// bus_select_rr_pkg: shared bus constants (default sizes) and select-mode encoding
package bus_select_rr_pkg;
   localparam int BUS_WIDTH = 16;
   localparam int BUS_NCH   = 8;
   localparam int BUS_SELW  = 3;
   typedef enum logic {MODE_DIRECT = 1'b0, MODE_RR = 1'b1} mode_e;
endpackage

// File: rtl/bus_select_rr_pick.sv
// rr_pick: wrap-around priority search; finds first set req at or above ptr, wrapping NCH-1 -> 0
//   req   : per-channel request flags
//   ptr   : search start channel (always < NCH)
//   found : some request is set
//   idx   : index of the chosen channel (0 when none found)
module rr_pick
   import bus_select_rr_pkg::*;
#(
   parameter int NCH  = BUS_NCH,
   parameter int SELW = BUS_SELW
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && req[(int'(ptr) + i) % NCH]) begin
            found = 1'b1;
            idx   = SELW'((int'(ptr) + i) % NCH);
         end
      end
   end
endmodule

// File: rtl/bus_select_rr.sv
// bus_select_rr: registered channel selector, direct (S) or round-robin, with valid/ready output
//   Clock, Resetn : clock, async active-low reset
//   mode, S       : 0 = direct select via S, 1 = round-robin among req
//   req, din      : per-channel data-available flags and packed channel data
//   ready         : downstream accepts Q this cycle
//   Q, valid      : registered selected word and its occupancy flag
//   grant         : one-hot, combinational, on the channel captured this cycle
//   sel_out       : index of the channel held in Q
module bus_select_rr
   import bus_select_rr_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int NCH   = BUS_NCH,
   parameter int SELW  = BUS_SELW
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 mode,
   input  logic [SELW-1:0]      S,
   input  logic [NCH-1:0]       req,
   input  logic [NCH*WIDTH-1:0] din,
   input  logic                 ready,
   output logic [WIDTH-1:0]     Q,
   output logic                 valid,
   output logic [NCH-1:0]       grant,
   output logic [SELW-1:0]      sel_out
);
   logic [WIDTH-1:0]      q_q, q_d;
   logic                  valid_q, valid_d;
   logic [SELW-1:0]       sel_q, sel_d, ptr_q, ptr_d;
   logic [(1<<SELW)-1:0]  req_ext;
   logic                  rr_found, eligible, load;
   logic [SELW-1:0]       rr_idx, pick;

   rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (rr_found),
      .idx   (rr_idx)
   );

   // req_ext pads req to the full S range so an out-of-range S reads as "no request"
   always_comb begin
      req_ext          = '0;
      req_ext[NCH-1:0] = req;
      pick     = (mode == MODE_RR) ? rr_idx : S;
      eligible = (mode == MODE_RR) ? rr_found : ((int'(S) < NCH) && req_ext[S]);
      load     = Resetn && (!valid_q || ready) && eligible;
      grant    = load ? (NCH'(1) << pick) : '0;
      q_d      = load ? din[int'(pick)*WIDTH +: WIDTH] : q_q;
      sel_d    = load ? pick : sel_q;
      valid_d  = load || (valid_q && !ready);
      ptr_d    = (load && mode == MODE_RR) ? ((rr_idx == SELW'(NCH-1)) ? '0 : rr_idx + 1'b1) : ptr_q;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         q_q     <= '0;
         valid_q <= 1'b0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         q_q     <= q_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign Q       = q_q;
   assign valid   = valid_q;
   assign sel_out = sel_q;
endmodule

// File: tb/tb_bus_select_rr.sv
// tb_bus_select_rr: directed self-checking bench for bus_select_rr (NCH=8 and NCH=6 instances)
module tb_bus_select_rr;
   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          mode, ready, mode6, ready6;
   logic [2:0]    S, S6, sel_out, sel_out6;
   logic [7:0]    req, grant;
   logic [5:0]    req6, grant6;
   logic [127:0]  din;
   logic [95:0]   din6;
   logic [15:0]   Q, Q6;
   logic          valid, valid6;
   int            checks = 0;
   int            errors = 0;

   always #5 Clock = ~Clock;

   bus_select_rr dut (
      .Clock(Clock), .Resetn(Resetn), .mode(mode), .S(S), .req(req), .din(din),
      .ready(ready), .Q(Q), .valid(valid), .grant(grant), .sel_out(sel_out)
   );

   bus_select_rr #(.WIDTH(16), .NCH(6), .SELW(3)) dut6 (
      .Clock(Clock), .Resetn(Resetn), .mode(mode6), .S(S6), .req(req6), .din(din6),
      .ready(ready6), .Q(Q6), .valid(valid6), .grant(grant6), .sel_out(sel_out6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clock);
      @(negedge Clock);
   endtask

   initial begin
      mode = 1'b1; S = '0; req = 8'hFF; ready = 1'b1;
      mode6 = 1'b0; S6 = '0; req6 = '0; ready6 = 1'b0;
      for (int k = 0; k < 8; k++) din[k*16 +: 16] = 16'hA000 + 16'(k);
      for (int k = 0; k < 6; k++) din6[k*16 +: 16] = 16'hC000 + 16'(k);
      #1;
      check("rst_q", Q, 0);
      check("rst_valid", valid, 0);
      check("rst_sel", sel_out, 0);
      check("rst_grant", grant, 0);
      tick;
      tick;
      check("rst_hold_valid", valid, 0);
      // direct select of ch5
      Resetn = 1'b1;
      mode = 1'b0; S = 3'd5; req = 8'h20; din[5*16 +: 16] = 16'hBEEF;
      #1 check("dir_grant", grant, 8'h20);
      tick;
      check("dir_q", Q, 16'hBEEF);
      check("dir_sel", sel_out, 5);
      check("dir_valid", valid, 1);
      check("dir_ptr", dut.ptr_q, 0);
      // no request on S: nothing loads, ready drains the held word
      req = 8'h00; din[5*16 +: 16] = 16'hA005;
      #1 check("dir_noreq_grant", grant, 0);
      tick;
      check("dir_drain_valid", valid, 0);
      check("dir_hold_q", Q, 16'hBEEF);
      check("dir_hold_sel", sel_out, 5);
      // round-robin, all requesting, one load per cycle
      mode = 1'b1; req = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         #1 check("rr_grant", grant, 32'(1) << (i % 8));
         tick;
         check("rr_q", Q, 16'hA000 + 16'(i % 8));
         check("rr_sel", sel_out, i % 8);
         check("rr_valid", valid, 1);
      end
      check("rr_ptr", dut.ptr_q, 2);
      // backpressure: held word stays, no grant, pointer frozen
      ready = 1'b0; req = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         #1 check("bp_grant", grant, 0);
         tick;
         check("bp_q", Q, 16'hA001);
         check("bp_sel", sel_out, 1);
         check("bp_valid", valid, 1);
         check("bp_ptr", dut.ptr_q, 2);
      end
      ready = 1'b1;
      #1 check("bp_release_grant", grant, 8'h04);
      tick;
      check("bp_release_sel", sel_out, 2);
      check("bp_release_ptr", dut.ptr_q, 3);
      // walk pointer to 6, then wrap
      req = 8'h08;
      #1 check("walk_grant3", grant, 8'h08);
      tick;
      req = 8'h20;
      #1 check("walk_grant5", grant, 8'h20);
      tick;
      check("walk_ptr", dut.ptr_q, 6);
      req = 8'h05;
      #1 check("wrap_grant0", grant, 8'h01);
      tick;
      check("wrap_ptr1", dut.ptr_q, 1);
      check("wrap_sel0", sel_out, 0);
      #1 check("wrap_grant2", grant, 8'h04);
      tick;
      check("wrap_ptr3", dut.ptr_q, 3);
      check("wrap_sel2", sel_out, 2);
      // asynchronous reset between edges while a word is held
      ready = 1'b0;
      tick;
      check("pre_rst_valid", valid, 1);
      #2 Resetn = 1'b0;
      #1;
      check("arst_q", Q, 0);
      check("arst_valid", valid, 0);
      check("arst_sel", sel_out, 0);
      check("arst_ptr", dut.ptr_q, 0);
      check("arst_grant", grant, 0);
      @(negedge Clock);
      Resetn = 1'b1; mode = 1'b1; req = 8'h80; ready = 1'b1;
      #1 check("post_rst_grant", grant, 8'h80);
      tick;
      check("post_rst_sel", sel_out, 7);
      check("post_rst_q", Q, 16'hA007);
      check("post_rst_ptr", dut.ptr_q, 0);
      req = 8'h00;
      // NCH=6 instance: load ch2, then out-of-range select
      mode6 = 1'b0; S6 = 3'd2; req6 = 6'h3F; ready6 = 1'b0;
      #1 check("n6_grant2", grant6, 6'h04);
      tick;
      check("n6_q", Q6, 16'hC002);
      check("n6_valid", valid6, 1);
      S6 = 3'd7;
      #1 check("n6_bad_grant", grant6, 0);
      tick;
      check("n6_bad_hold", valid6, 1);
      ready6 = 1'b1;
      #1 check("n6_bad_grant_rdy", grant6, 0);
      tick;
      check("n6_bad_clear", valid6, 0);
      check("n6_bad_q", Q6, 16'hC002);
      check("n6_bad_sel", sel_out6, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
